// File: rtl/mem_bus_split.sv
// One-master to N-slave valid/ready bus splitter with registered decode,
// transaction timeout and a sticky first-error log.
module mem_bus_split #(
    parameter int unsigned             NSLAVES    = 3,
    parameter logic [NSLAVES*32-1:0]   SLAVE_BASE = {32'h03000000, 32'h00000000, 32'h00050000},
    parameter logic [NSLAVES*32-1:0]   SLAVE_MASK = {3{32'hFFFF0000}},
    parameter int unsigned             TIMEOUT    = 256,
    parameter logic [31:0]             ERR_RDATA  = 32'h00000000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  logic [31:0]             mem_addr,
    input  logic [31:0]             mem_wdata,
    input  logic [3:0]              mem_wstrb,
    output logic [31:0]             mem_rdata,
    output logic [NSLAVES-1:0]      s_valid,
    input  logic [NSLAVES-1:0]      s_ready,
    input  logic [NSLAVES*32-1:0]   s_rdata,
    output logic [31:0]             s_addr,
    output logic [31:0]             s_wdata,
    output logic [3:0]              s_wstrb,
    output logic                    err_valid,
    output logic [1:0]              err_code,
    output logic [31:0]             err_addr,
    input  logic                    err_clr
);

    localparam int unsigned SW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;
    localparam logic [1:0] CODE_UNMAPPED = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT  = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_ERR
    } state_e;

    state_e        state_q, state_d;
    logic [SW-1:0] sel_q, sel_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          err_valid_q, err_valid_d;
    logic [1:0]    err_code_q, err_code_d;
    logic [31:0]   err_addr_q, err_addr_d;

    logic          hit;
    logic [SW-1:0] hit_idx;
    logic          sel_ready;
    logic [31:0]   sel_rdata;
    logic          log_en;
    logic [1:0]    log_code;

    assign s_addr  = mem_addr;
    assign s_wdata = mem_wdata;
    assign s_wstrb = mem_wstrb;

    // Scan downwards so the lowest matching index is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = NSLAVES; i > 0; i--) begin
            if ((mem_addr & SLAVE_MASK[32*(i-1) +: 32]) == SLAVE_BASE[32*(i-1) +: 32]) begin
                hit     = 1'b1;
                hit_idx = SW'(i - 1);
            end
        end
    end

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int unsigned i = 0; i < NSLAVES; i++) begin
            if (sel_q == SW'(i)) begin
                sel_ready = s_ready[i];
                sel_rdata = s_rdata[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cnt_d     = cnt_q;
        s_valid   = '0;
        mem_ready = 1'b0;
        mem_rdata = ERR_RDATA;
        log_en    = 1'b0;
        log_code  = 2'b00;
        case (state_q)
            S_IDLE: begin
                if (mem_valid) begin
                    if (hit) begin
                        sel_d   = hit_idx;
                        cnt_d   = '0;
                        state_d = S_BUSY;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q + 16'd1;
                if (!mem_valid) begin
                    state_d = S_IDLE;
                end else if (sel_ready) begin
                    s_valid   = NSLAVES'(1) << sel_q;
                    mem_ready = 1'b1;
                    mem_rdata = sel_rdata;
                    state_d   = S_IDLE;
                end else if (cnt_q == 16'(TIMEOUT - 1)) begin
                    mem_ready = 1'b1;
                    log_en    = 1'b1;
                    log_code  = CODE_TIMEOUT;
                    state_d   = S_IDLE;
                end else begin
                    s_valid = NSLAVES'(1) << sel_q;
                end
            end
            S_ERR: begin
                mem_ready = 1'b1;
                log_en    = 1'b1;
                log_code  = CODE_UNMAPPED;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // A new log beats a simultaneous clear; otherwise the first error sticks.
    always_comb begin
        err_valid_d = err_valid_q;
        err_code_d  = err_code_q;
        err_addr_d  = err_addr_q;
        if (log_en && (!err_valid_q || err_clr)) begin
            err_valid_d = 1'b1;
            err_code_d  = log_code;
            err_addr_d  = mem_addr;
        end else if (err_clr) begin
            err_valid_d = 1'b0;
            err_code_d  = '0;
            err_addr_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            sel_q       <= '0;
            cnt_q       <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= '0;
            err_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
            err_addr_q  <= err_addr_d;
        end
    end

    assign err_valid = err_valid_q;
    assign err_code  = err_code_q;
    assign err_addr  = err_addr_q;

endmodule

// File: tb/tb_mem_bus_split.sv
// Randomized transaction bench for mem_bus_split with a cycle-schedule model
// of each transaction and a per-cycle compare process.
module tb_mem_bus_split;

    localparam int N  = 3;
    localparam int TO = 8;
    localparam logic [N*32-1:0] BASES = {32'h03000000, 32'h00000000, 32'h00050000};
    localparam logic [N*32-1:0] MASKS = {3{32'hFFFF0000}};
    localparam logic [31:0]     ERRD  = 32'hDEADBEEF;

    logic            clk = 1'b0;
    logic            rst;
    logic            mem_valid;
    logic            mem_ready;
    logic [31:0]     mem_addr;
    logic [31:0]     mem_wdata;
    logic [3:0]      mem_wstrb;
    logic [31:0]     mem_rdata;
    logic [N-1:0]    s_valid;
    logic [N-1:0]    s_ready;
    logic [N*32-1:0] s_rdata;
    logic [31:0]     s_addr;
    logic [31:0]     s_wdata;
    logic [3:0]      s_wstrb;
    logic            err_valid;
    logic [1:0]      err_code;
    logic [31:0]     err_addr;
    logic            err_clr;

    mem_bus_split #(
        .NSLAVES    (N),
        .SLAVE_BASE (BASES),
        .SLAVE_MASK (MASKS),
        .TIMEOUT    (TO),
        .ERR_RDATA  (ERRD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_rdata   (s_rdata),
        .s_addr    (s_addr),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .err_valid (err_valid),
        .err_code  (err_code),
        .err_addr  (err_addr),
        .err_clr   (err_clr)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Expected outputs for the current cycle and the model's error log.
    bit          chk_en = 1'b0;
    logic [N-1:0] exp_sv;
    logic        exp_rdy;
    logic [31:0] exp_rd;
    logic        m_ev;
    logic [1:0]  m_ec;
    logic [31:0] m_ea;
    int          clr_mode = 0;

    int          last_c;
    logic [31:0] last_rd;
    logic [N-1:0] last_sv;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("s_valid",   32'(s_valid), 32'(exp_sv));
            check("mem_ready", 32'(mem_ready), 32'(exp_rdy));
            check("mem_rdata", mem_rdata, exp_rd);
            check("err_valid", 32'(err_valid), 32'(m_ev));
            check("err_code",  32'(err_code), 32'(m_ec));
            check("err_addr",  err_addr, m_ea);
            check("s_addr",    s_addr, mem_addr);
            check("s_wdata",   s_wdata, mem_wdata);
            check("s_wstrb",   32'(s_wstrb), 32'(mem_wstrb));
        end
    end

    function automatic int decode(input logic [31:0] a);
        for (int i = 0; i < N; i++)
            if ((a & MASKS[32*i +: 32]) == BASES[32*i +: 32]) return i;
        return -1;
    endfunction

    function automatic logic pick_clr(input bit logcyc);
        case (clr_mode)
            1:       return ($urandom_range(0, 9) == 0);
            2:       return logcyc;
            default: return 1'b0;
        endcase
    endfunction

    // Advance one clock edge and apply the error-log rules to the model.
    task automatic tick(input bit log_e, input logic [1:0] code);
        @(posedge clk);
        if (rst) begin
            m_ev = 1'b0; m_ec = 2'b00; m_ea = 32'h0;
        end else if (log_e && (!m_ev || err_clr)) begin
            m_ev = 1'b1; m_ec = code; m_ea = mem_addr;
        end else if (err_clr) begin
            m_ev = 1'b0; m_ec = 2'b00; m_ea = 32'h0;
        end
        #1;
    endtask

    task automatic idle(input int n, input logic clr);
        for (int k = 0; k < n; k++) begin
            mem_valid = 1'b0;
            s_ready   = N'($urandom);
            err_clr   = clr;
            exp_sv = '0; exp_rdy = 1'b0; exp_rd = ERRD;
            tick(1'b0, 2'b00);
        end
    endtask

    task automatic sample_end(input int c);
        @(negedge clk);
        last_c  = c;
        last_rd = mem_rdata;
        last_sv = s_valid;
    endtask

    // lat: wait cycles before the selected slave answers (>= TO: never).
    // wd_at: BUSY cycle in which the master withdraws (0: never).
    task automatic xact(input logic [31:0] a, input logic [3:0] ws, input logic [31:0] wd,
                        input logic [31:0] rd_sel, input int lat, input int wd_at);
        int t;
        logic [N-1:0] r;
        t = decode(a);
        mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
        for (int i = 0; i < N; i++) s_rdata[32*i +: 32] = $urandom;
        if (t >= 0) s_rdata[32*t +: 32] = rd_sel;
        s_ready = N'($urandom);
        err_clr = pick_clr(1'b0);
        exp_sv = '0; exp_rdy = 1'b0; exp_rd = ERRD;
        tick(1'b0, 2'b00);
        if (t < 0) begin
            s_ready = N'($urandom);
            err_clr = pick_clr(1'b1);
            exp_sv = '0; exp_rdy = 1'b1; exp_rd = ERRD;
            sample_end(1);
            tick(1'b1, 2'b01);
        end else begin
            for (int c = 1; c <= TO; c++) begin
                r = N'($urandom);
                if (wd_at == c) begin
                    mem_valid = 1'b0;
                    r[t] = 1'b0; s_ready = r;
                    err_clr = pick_clr(1'b0);
                    exp_sv = '0; exp_rdy = 1'b0; exp_rd = ERRD;
                    sample_end(c);
                    tick(1'b0, 2'b00);
                    break;
                end
                r[t] = (c == lat + 1);
                s_ready = r;
                if (c == lat + 1) begin
                    err_clr = pick_clr(1'b0);
                    exp_sv = '0; exp_sv[t] = 1'b1; exp_rdy = 1'b1; exp_rd = rd_sel;
                    sample_end(c);
                    tick(1'b0, 2'b00);
                    break;
                end else if (c == TO) begin
                    err_clr = pick_clr(1'b1);
                    exp_sv = '0; exp_rdy = 1'b1; exp_rd = ERRD;
                    sample_end(c);
                    tick(1'b1, 2'b10);
                    break;
                end else begin
                    err_clr = pick_clr(1'b0);
                    exp_sv = '0; exp_sv[t] = 1'b1; exp_rdy = 1'b0; exp_rd = ERRD;
                    tick(1'b0, 2'b00);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, wd_at, t;
        logic [31:0] a;

        rst = 1'b1; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        s_ready = '0; s_rdata = '0; err_clr = 1'b0;
        m_ev = 1'b0; m_ec = 2'b00; m_ea = 32'h0;
        exp_sv = '0; exp_rdy = 1'b0; exp_rd = ERRD;
        tick(1'b0, 2'b00);
        chk_en = 1'b1;
        tick(1'b0, 2'b00);
        rst = 1'b0;
        check("reset_err_valid", 32'(err_valid), 32'h0);
        check("reset_mem_ready", 32'(mem_ready), 32'h0);

        // ROM zero-wait read
        xact(32'h00050004, 4'h0, 32'h0, 32'h12345678, 0, 0);
        check("rom_latency", 32'(last_c), 32'd1);
        check("rom_s_valid", 32'(last_sv), 32'b001);
        check("rom_rdata", last_rd, 32'h12345678);
        check("rom_no_err", 32'(err_valid), 32'h0);

        // GPIO write with 3 wait cycles, back-to-back with the next request
        xact(32'h03000000, 4'hF, 32'h000000A5, 32'h0, 3, 0);
        check("gpio_latency", 32'(last_c), 32'd4);
        check("gpio_s_valid", 32'(last_sv), 32'b100);

        // RAM never ready: timeout
        xact(32'h00000010, 4'h0, 32'h0, 32'h0, 1000, 0);
        check("to_latency", 32'(last_c), 32'(TO));
        check("to_s_valid", 32'(last_sv), 32'b000);
        check("to_rdata", last_rd, ERRD);
        check("to_err_code", 32'(err_code), 32'h2);
        check("to_err_addr", err_addr, 32'h00000010);
        idle(1, 1'b1);
        check("clr_err_valid", 32'(err_valid), 32'h0);

        // Unmapped, then a second error must not overwrite the first
        xact(32'h10000000, 4'h0, 32'h0, 32'h0, 0, 0);
        check("unm_latency", 32'(last_c), 32'd1);
        check("unm_rdata", last_rd, ERRD);
        check("unm_err_code", 32'(err_code), 32'h1);
        check("unm_err_addr", err_addr, 32'h10000000);
        xact(32'h20000000, 4'hF, 32'h1, 32'h0, 0, 0);
        check("sticky_err_addr", err_addr, 32'h10000000);
        idle(1, 1'b1);
        check("clr_code", 32'(err_code), 32'h0);
        check("clr_addr", err_addr, 32'h0);

        // Clear coinciding with a new log: the new error is captured
        xact(32'h30000000, 4'h0, 32'h0, 32'h0, 0, 0);
        clr_mode = 2;
        xact(32'h40000000, 4'h0, 32'h0, 32'h0, 0, 0);
        clr_mode = 0;
        check("clr_vs_log_valid", 32'(err_valid), 32'h1);
        check("clr_vs_log_addr", err_addr, 32'h40000000);

        // Reset while BUSY
        mem_valid = 1'b1; mem_addr = 32'h00000020; mem_wstrb = 4'h0;
        s_ready = '0; err_clr = 1'b0;
        exp_sv = '0; exp_rdy = 1'b0; exp_rd = ERRD;
        tick(1'b0, 2'b00);
        exp_sv = 3'b010;
        tick(1'b0, 2'b00);
        rst = 1'b1;
        tick(1'b0, 2'b00);
        rst = 1'b0; mem_valid = 1'b0; s_ready = '1;
        exp_sv = '0; exp_rdy = 1'b0; exp_rd = ERRD;
        check("rst_busy_err_valid", 32'(err_valid), 32'h0);
        tick(1'b0, 2'b00);
        xact(32'h00000024, 4'h0, 32'h0, 32'hCAFEF00D, 1, 0);
        check("post_rst_rdata", last_rd, 32'hCAFEF00D);
        check("post_rst_latency", 32'(last_c), 32'd2);

        // Randomized traffic
        clr_mode = 1;
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                a = $urandom;
            end else begin
                t = $urandom_range(0, N - 1);
                a = BASES[32*t +: 32] | ($urandom & ~MASKS[32*t +: 32]);
            end
            lat = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(0, TO - 1);
            wd_at = 0;
            if (lat >= 1 && $urandom_range(0, 9) == 0)
                wd_at = $urandom_range(1, (lat < TO - 1) ? lat : TO - 1);
            xact(a, 4'($urandom), $urandom, $urandom, lat, wd_at);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2), pick_clr(1'b0));
        end
        idle(2, 1'b0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
